// File: rtl/pcie_dma_demux.sv
// Splits the PCIe DMA write-data stream by header tag: TS payload is packed 2:1
// into OTT RAM words, command payload becomes a framed sof/eof stream, others are drained.
module pcie_dma_demux #(
  parameter int          RAM_AW    = 13,
  parameter logic [7:0]  TS_TAG    = 8'h50,
  parameter logic [7:0]  CMD_TAG   = 8'h05,
  parameter int          LEN_W     = 16,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dma_read_start,
  input  logic                 dma_wdata_en,
  input  logic [63:0]          dma_wdata,
  output logic                 dma_wdata_rdy,
  output logic                 ott_ram_wr,
  output logic [RAM_AW-1:0]    ott_ram_waddr,
  output logic [127:0]         ott_ram_dina,
  output logic                 ott_ram_clear,
  output logic [63:0]          cmd_dout,
  output logic                 cmd_dout_en,
  output logic                 cmd_sof,
  output logic                 cmd_eof,
  input  logic                 cmd_rdy,
  output logic                 ram_ovf,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    TS   = 3'd2,
    CMD  = 3'd3,
    DROP = 3'd4
  } state_e;

  state_e               state_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     cnt_q;
  logic [63:0]          hi_q;
  logic [RAM_AW:0]      wr_idx_q;
  logic                 pkt_ovf_q;
  logic                 ram_wr_q;
  logic [RAM_AW-1:0]    ram_waddr_q;
  logic [127:0]         ram_dina_q;
  logic                 ram_clear_q;
  logic [63:0]          cmd_dout_q;
  logic                 cmd_en_q;
  logic                 cmd_sof_q;
  logic                 cmd_eof_q;
  logic                 ram_ovf_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic                 accept;
  logic [LEN_W-1:0]     hdr_n_d;
  logic [LEN_W-1:0]     hdr_p_d;
  logic [LEN_W-1:0]     cnt_d;
  logic                 last_beat;
  logic                 wr_full;
  logic [63:0]          beat_rev;

  function automatic logic [63:0] byte_rev(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*(7-i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Valid/ready: a beat transfers on any cycle where dma_wdata_en & dma_wdata_rdy.
  // Only the command path ever stalls the source, following cmd_rdy directly.
  assign dma_wdata_rdy = !((state_q == CMD) && !cmd_rdy);

  always_comb begin
    accept    = dma_wdata_en & dma_wdata_rdy;
    hdr_n_d   = LEN_W'({dma_wdata[31:24], dma_wdata[39:32]});
    hdr_p_d   = (hdr_n_d == '0) ? '0 : hdr_n_d - 1'b1;
    cnt_d     = cnt_q + 1'b1;
    last_beat = (cnt_d == len_q);
    wr_full   = wr_idx_q[RAM_AW];
    beat_rev  = byte_rev(dma_wdata);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      wr_idx_q    <= '0;
      pkt_ovf_q   <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_dina_q  <= '0;
      ram_clear_q <= 1'b0;
      cmd_dout_q  <= '0;
      cmd_en_q    <= 1'b0;
      cmd_sof_q   <= 1'b0;
      cmd_eof_q   <= 1'b0;
      ram_ovf_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      ram_wr_q    <= 1'b0;
      cmd_dout_q  <= '0;
      cmd_en_q    <= 1'b0;
      cmd_sof_q   <= 1'b0;
      cmd_eof_q   <= 1'b0;
      // Stays high for the cycle after the last TS beat so the final write is covered.
      ram_clear_q <= (state_q == TS);

      case (state_q)
        IDLE: begin
          if (dma_read_start) state_q <= HDR;
        end

        HDR: begin
          if (accept) begin
            len_q <= hdr_p_d;
            cnt_q <= '0;
            if (hdr_p_d == '0) begin
              state_q <= IDLE;
            end else if (dma_wdata[7:0] == TS_TAG) begin
              state_q     <= TS;
              ram_clear_q <= 1'b1;
              wr_idx_q    <= '0;
              pkt_ovf_q   <= 1'b0;
            end else if (dma_wdata[7:0] == CMD_TAG) begin
              state_q <= CMD;
            end else begin
              state_q   <= DROP;
              err_cnt_q <= sat_inc(err_cnt_q);
            end
          end
        end

        TS: begin
          if (accept) begin
            cnt_q <= cnt_d;
            if (last_beat) state_q <= IDLE;
            if (!cnt_q[0]) hi_q <= beat_rev;
            if (cnt_q[0] || last_beat) begin
              if (wr_full) begin
                // wr_idx stops at the RAM depth, so the rest of the packet stays suppressed.
                if (!pkt_ovf_q) begin
                  pkt_ovf_q <= 1'b1;
                  ram_ovf_q <= 1'b1;
                  err_cnt_q <= sat_inc(err_cnt_q);
                end
              end else begin
                ram_wr_q    <= 1'b1;
                ram_waddr_q <= wr_idx_q[RAM_AW-1:0];
                wr_idx_q    <= wr_idx_q + 1'b1;
                ram_dina_q  <= cnt_q[0] ? {hi_q, beat_rev} : {beat_rev, 64'h0};
              end
            end
          end
        end

        CMD: begin
          if (accept) begin
            cnt_q      <= cnt_d;
            cmd_dout_q <= dma_wdata;
            cmd_en_q   <= 1'b1;
            cmd_sof_q  <= (cnt_q == '0);
            cmd_eof_q  <= last_beat;
            if (last_beat) state_q <= IDLE;
          end
        end

        DROP: begin
          if (accept) begin
            cnt_q <= cnt_d;
            if (last_beat) state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign ott_ram_wr    = ram_wr_q;
  assign ott_ram_waddr = ram_waddr_q;
  assign ott_ram_dina  = ram_dina_q;
  assign ott_ram_clear = ram_clear_q;
  assign cmd_dout      = cmd_dout_q;
  assign cmd_dout_en   = cmd_en_q;
  assign cmd_sof       = cmd_sof_q;
  assign cmd_eof       = cmd_eof_q;
  assign ram_ovf       = ram_ovf_q;
  assign err_cnt       = err_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pcie_dma_demux.sv
// Directed bench for pcie_dma_demux: a full-depth instance and a 4-word-RAM instance
// share one driver; monitors pop expected RAM writes and command beats from queues.
module tb_pcie_dma_demux;

  localparam logic [7:0] TS_TAG  = 8'h50;
  localparam logic [7:0] CMD_TAG = 8'h05;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        en;
  logic [63:0] wdata;
  logic        cmd_rdy;
  logic        sel_small;

  int checks = 0;
  int errors = 0;

  logic [140:0] exp_ram_q[$];
  logic [129:0] exp_ram_s_q[$];
  logic [65:0]  exp_cmd_q[$];

  // full-depth instance
  logic         rdy_b, wr_b, clear_b, cmd_en_b, sof_b, eof_b, ovf_b;
  logic [12:0]  waddr_b;
  logic [127:0] dina_b;
  logic [63:0]  dout_b;
  logic [15:0]  err_b;
  logic [2:0]   state_b;

  // 4-word RAM instance
  logic         rdy_s, wr_s, clear_s, cmd_en_s, sof_s, eof_s, ovf_s;
  logic [1:0]   waddr_s;
  logic [127:0] dina_s;
  logic [63:0]  dout_s;
  logic [15:0]  err_s;
  logic [2:0]   state_s;

  logic start_b, en_b, start_s, en_s, rdy_sel;
  assign start_b = start & ~sel_small;
  assign en_b    = en & ~sel_small;
  assign start_s = start & sel_small;
  assign en_s    = en & sel_small;
  assign rdy_sel = sel_small ? rdy_s : rdy_b;

  pcie_dma_demux #(.RAM_AW(13)) u_dut (
    .clk(clk), .rst(rst), .dma_read_start(start_b), .dma_wdata_en(en_b),
    .dma_wdata(wdata), .dma_wdata_rdy(rdy_b), .ott_ram_wr(wr_b),
    .ott_ram_waddr(waddr_b), .ott_ram_dina(dina_b), .ott_ram_clear(clear_b),
    .cmd_dout(dout_b), .cmd_dout_en(cmd_en_b), .cmd_sof(sof_b), .cmd_eof(eof_b),
    .cmd_rdy(cmd_rdy), .ram_ovf(ovf_b), .err_cnt(err_b), .dbg_state(state_b)
  );

  pcie_dma_demux #(.RAM_AW(2)) u_small (
    .clk(clk), .rst(rst), .dma_read_start(start_s), .dma_wdata_en(en_s),
    .dma_wdata(wdata), .dma_wdata_rdy(rdy_s), .ott_ram_wr(wr_s),
    .ott_ram_waddr(waddr_s), .ott_ram_dina(dina_s), .ott_ram_clear(clear_s),
    .cmd_dout(dout_s), .cmd_dout_en(cmd_en_s), .cmd_sof(sof_s), .cmd_eof(eof_s),
    .cmd_rdy(cmd_rdy), .ram_ovf(ovf_s), .err_cnt(err_s), .dbg_state(state_s)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] hdr(input logic [7:0] tag, input logic [15:0] n);
    logic [63:0] d;
    d        = 64'h0;
    d[7:0]   = tag;
    d[31:24] = n[15:8];
    d[39:32] = n[7:0];
    return d;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d);
    logic acc;
    int   budget;
    acc    = 1'b0;
    budget = 0;
    en     = 1'b1;
    wdata  = d;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = rdy_sel;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_beat_timeout: got rdy=0 expected accept within 50 cycles");
    end
    en = 1'b0;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst) begin
      if (wr_b) begin
        checks++;
        if (exp_ram_q.size() == 0) begin
          errors++;
          $display("FAIL ram_wr_unexpected: got addr %0h data %0h expected no write", waddr_b, dina_b);
        end else begin
          logic [140:0] e;
          e = exp_ram_q.pop_front();
          if ({waddr_b, dina_b} !== e) begin
            errors++;
            $display("FAIL ram_wr: got %0h expected %0h", {waddr_b, dina_b}, e);
          end
        end
      end
      if (wr_s) begin
        checks++;
        if (exp_ram_s_q.size() == 0) begin
          errors++;
          $display("FAIL ram_wr_small_unexpected: got addr %0h data %0h expected no write", waddr_s, dina_s);
        end else begin
          logic [129:0] e;
          e = exp_ram_s_q.pop_front();
          if ({waddr_s, dina_s} !== e) begin
            errors++;
            $display("FAIL ram_wr_small: got %0h expected %0h", {waddr_s, dina_s}, e);
          end
        end
      end
      if (cmd_en_b) begin
        checks++;
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got %0h expected no beat", {sof_b, eof_b, dout_b});
        end else begin
          logic [65:0] e;
          e = exp_cmd_q.pop_front();
          if ({sof_b, eof_b, dout_b} !== e) begin
            errors++;
            $display("FAIL cmd_beat: got %0h expected %0h", {sof_b, eof_b, dout_b}, e);
          end
        end
      end else if (sof_b || eof_b || dout_b != 64'h0) begin
        checks++;
        errors++;
        $display("FAIL cmd_idle_zero: got %0h expected 0", {sof_b, eof_b, dout_b});
      end
      if (cmd_en_s || sof_s || eof_s || dout_s != 64'h0) begin
        checks++;
        errors++;
        $display("FAIL cmd_small_activity: got %0h expected 0", {cmd_en_s, sof_s, eof_s, dout_s});
      end
    end
  end

  // stimulus
  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    en        = 1'b0;
    wdata     = 64'h0;
    cmd_rdy   = 1'b1;
    sel_small = 1'b0;
    tick(3);

    chk("rst_rdy", rdy_b, 1);
    chk("rst_wr", wr_b, 0);
    chk("rst_waddr", waddr_b, 0);
    chk("rst_dina", dina_b, 0);
    chk("rst_clear", clear_b, 0);
    chk("rst_cmd", {cmd_en_b, sof_b, eof_b, dout_b}, 0);
    chk("rst_ovf", ovf_b, 0);
    chk("rst_err", err_b, 0);
    chk("rst_state", state_b, ST_IDLE);

    @(negedge clk);
    rst = 1'b1;
    tick(1);

    // TS, N=5: four payload beats -> two writes
    exp_ram_q.push_back({13'd0, 64'h0100000000000000, 64'h0200000000000000});
    exp_ram_q.push_back({13'd1, 64'h0300000000000000, 64'h0400000000000000});
    pulse_start();
    send_beat(hdr(TS_TAG, 16'd5));
    chk("ts5_clear_hdr", clear_b, 1);
    for (int i = 1; i <= 4; i++) begin
      send_beat(64'(i));
      chk("ts5_clear_beat", clear_b, 1);
    end
    tick(1);
    chk("ts5_clear_off", clear_b, 0);
    chk("ts5_state", state_b, ST_IDLE);
    tick(2);
    chk("ts5_err", err_b, 0);
    chk("ts5_writes_done", exp_ram_q.size(), 0);

    // TS, N=4: odd payload, last word zero-padded
    exp_ram_q.push_back({13'd0, 64'h8877665544332211, 64'h0807060504030201});
    exp_ram_q.push_back({13'd1, 64'h0DF0FECAEFBEADDE, 64'h0});
    pulse_start();
    send_beat(hdr(TS_TAG, 16'd4));
    send_beat(64'h1122334455667788);
    send_beat(64'h0102030405060708);
    send_beat(64'hDEADBEEFCAFEF00D);
    tick(3);
    chk("ts4_writes_done", exp_ram_q.size(), 0);
    chk("ts4_clear_off", clear_b, 0);

    // CMD, N=4 with cmd_rdy 1,0,0,1
    exp_cmd_q.push_back({1'b1, 1'b0, 64'hC0DE000000000001});
    exp_cmd_q.push_back({1'b0, 1'b0, 64'hC0DE000000000002});
    exp_cmd_q.push_back({1'b0, 1'b1, 64'hC0DE000000000003});
    pulse_start();
    send_beat(hdr(CMD_TAG, 16'd4));
    chk("cmd_state", state_b, ST_CMD);
    send_beat(64'hC0DE000000000001);
    cmd_rdy = 1'b0;
    en      = 1'b1;
    wdata   = 64'hC0DE000000000002;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("cmd_rdy_low", rdy_b, 0);
      @(posedge clk);
      #1;
    end
    cmd_rdy = 1'b1;
    #1;
    chk("cmd_rdy_high", rdy_b, 1);
    send_beat(64'hC0DE000000000002);
    send_beat(64'hC0DE000000000003);
    tick(3);
    chk("cmd_beats_done", exp_cmd_q.size(), 0);
    chk("cmd_state_idle", state_b, ST_IDLE);

    // unknown tag, N=3: drained and counted
    pulse_start();
    send_beat(hdr(8'h77, 16'd3));
    chk("drop_err", err_b, 1);
    send_beat(64'hAAAA5555AAAA5555);
    chk("drop_state_mid", state_b == ST_IDLE, 0);
    send_beat(64'h5555AAAA5555AAAA);
    chk("drop_state_idle", state_b, ST_IDLE);
    tick(2);
    chk("drop_err_hold", err_b, 1);

    // CMD N=1 and TS N=0: header only
    pulse_start();
    send_beat(hdr(CMD_TAG, 16'd1));
    chk("cmd1_state", state_b, ST_IDLE);
    pulse_start();
    send_beat(hdr(TS_TAG, 16'd0));
    chk("ts0_state", state_b, ST_IDLE);
    chk("ts0_clear", clear_b, 0);
    tick(2);
    chk("empty_err", err_b, 1);
    chk("empty_no_out", exp_ram_q.size() + exp_cmd_q.size(), 0);

    // 4-word RAM: TS N=11 overflows on the fifth write
    sel_small = 1'b1;
    for (int k = 0; k < 4; k++)
      exp_ram_s_q.push_back({2'(k), 8'(2*k+1), 56'h0, 8'(2*k+2), 56'h0});
    pulse_start();
    send_beat(hdr(TS_TAG, 16'd11));
    for (int i = 1; i <= 10; i++) send_beat(64'(i));
    chk("ovf_state", state_s, ST_IDLE);
    tick(3);
    chk("ovf_flag", ovf_s, 1);
    chk("ovf_err", err_s, 1);
    chk("ovf_writes_done", exp_ram_s_q.size(), 0);
    chk("ovf_clear_off", clear_s, 0);
    chk("ovf_big_untouched", ovf_b, 0);
    sel_small = 1'b0;

    // async reset in the middle of a TS packet
    pulse_start();
    send_beat(hdr(TS_TAG, 16'd5));
    send_beat(64'h1);
    chk("mid_clear", clear_b, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_clear", clear_b, 0);
    chk("mid_rst_state", state_b, ST_IDLE);
    chk("mid_rst_err", err_b, 0);
    chk("mid_rst_ovf_small", ovf_s, 0);
    chk("mid_rst_outs", {wr_b, cmd_en_b, sof_b, eof_b}, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    chk("post_rst_state", state_b, ST_IDLE);
    chk("post_rst_rdy", rdy_b, 1);

    // recovery packet, TS N=3
    exp_ram_q.push_back({13'd0, 64'hEFCDAB8967452301, 64'h1032547698BADCFE});
    pulse_start();
    send_beat(hdr(TS_TAG, 16'd3));
    send_beat(64'h0123456789ABCDEF);
    send_beat(64'hFEDCBA9876543210);
    tick(3);
    chk("recover_writes_done", exp_ram_q.size(), 0);

    chk("final_queues_empty", exp_ram_q.size() + exp_ram_s_q.size() + exp_cmd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
